// File: rtl/seg_scan_capture.sv
// seg_scan_capture: decodes a multiplexed 8-digit 7-seg bus back into HH:MM:SS.
// Ports: clk, rst_n | cs[7:0], seg[7:0] in | hh, mm, ss, colon_ok, frame_valid/err, sync_err out.
module seg_scan_capture #(
  parameter int SETTLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cs,
  input  logic [7:0] seg,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       colon_ok,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       sync_err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] C_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] C_HIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_COLLECT,
    S_CHECK
  } state_t;

  state_t r_state, w_nstate;

  logic [7:0] r_cs_m, r_cs_s, r_cs_p;
  logic [7:0] r_seg_m, r_seg_s, r_seg_d;

  logic [CW-1:0] r_cnt, w_cnt;
  logic          w_chg, w_settle;

  logic [7:0] w_sel;
  logic       w_onehot;
  logic [2:0] w_idx;

  logic [7:0] w_seg;
  logic [6:0] w_pat;
  logic       w_dp;
  logic [3:0] w_dval;
  logic       w_dok;

  logic [3:0] r_val [8];
  logic [7:0] r_ok;
  logic       r_dp2, r_dp5;
  logic [2:0] r_exp, w_nexp;
  logic       r_pend, w_pend_n;

  logic       w_cap;
  logic [2:0] w_cidx;
  logic       w_cok;
  logic       w_start;
  logic       w_se, w_fv, w_fe;

  logic [4:0] w_h;
  logic [5:0] w_m, w_s;
  logic       w_good;

  logic [4:0] r_hh;
  logic [5:0] r_mm, r_ss;
  logic       r_col, r_fv, r_fe, r_se;

  // Two-flop synchronizers, idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_m  <= 8'hFF;
      r_cs_s  <= 8'hFF;
      r_cs_p  <= 8'hFF;
      r_seg_m <= 8'hFF;
      r_seg_s <= 8'hFF;
      r_seg_d <= 8'hFF;
    end else begin
      r_cs_m  <= cs;
      r_cs_s  <= r_cs_m;
      r_cs_p  <= r_cs_s;
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_seg_d <= r_seg_s;
    end
  end

  // Saturates one above the hit value so a held
  // selection is sampled exactly once.
  assign w_chg = (r_cs_s != r_cs_p);

  always_comb begin
    w_cnt = r_cnt;
    if (w_chg) begin
      w_cnt = '0;
    end else if (r_cnt != C_MAX) begin
      w_cnt = r_cnt + CW'(1);
    end
  end

  assign w_settle = (w_cnt == C_HIT);

  assign w_sel    = ~r_cs_s;
  assign w_onehot = (w_sel != 8'd0) &&
                    ((w_sel & (w_sel - 8'd1)) == 8'd0);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_sel[i]) begin
        w_idx = 3'(i);
      end
    end
  end

  // A digit-0 settle seen during CHECK is replayed
  // in HUNT with the segment value from its own cycle.
  assign w_seg = (r_state == S_HUNT && r_pend) ?
                 r_seg_d : r_seg_s;
  assign w_pat = ~w_seg[6:0];
  assign w_dp  = ~w_seg[7];

  always_comb begin
    w_dval = 4'd0;
    w_dok  = 1'b1;
    case (w_pat)
      7'h3F: w_dval = 4'd0;
      7'h06: w_dval = 4'd1;
      7'h5B: w_dval = 4'd2;
      7'h4F: w_dval = 4'd3;
      7'h66: w_dval = 4'd4;
      7'h6D: w_dval = 4'd5;
      7'h7D: w_dval = 4'd6;
      7'h07: w_dval = 4'd7;
      7'h7F: w_dval = 4'd8;
      7'h6F: w_dval = 4'd9;
      default: w_dok = 1'b0;
    endcase
  end

  // Separator digits carry only dp; never invalid.
  assign w_cok = w_dok || (w_cidx == 3'd2) ||
                 (w_cidx == 3'd5);

  assign w_start = w_settle && (r_cs_s == 8'hFE);

  // Tens-digit bounds keep these narrow sums exact
  // whenever w_good can be true.
  assign w_h = 5'(r_val[0]) * 5'd10 + 5'(r_val[1]);
  assign w_m = 6'(r_val[3]) * 6'd10 + 6'(r_val[4]);
  assign w_s = 6'(r_val[6]) * 6'd10 + 6'(r_val[7]);

  assign w_good = (&r_ok) && (r_val[0] <= 4'd2) &&
                  (w_h <= 5'd23) &&
                  (r_val[3] <= 4'd5) &&
                  (r_val[6] <= 4'd5);

  always_comb begin
    w_nstate = r_state;
    w_cap    = 1'b0;
    w_cidx   = w_idx;
    w_nexp   = r_exp;
    w_pend_n = r_pend;
    w_se     = 1'b0;
    w_fv     = 1'b0;
    w_fe     = 1'b0;
    case (r_state)
      S_HUNT: begin
        w_pend_n = 1'b0;
        if (r_pend || w_start) begin
          w_cap    = 1'b1;
          w_cidx   = 3'd0;
          w_nexp   = 3'd1;
          w_nstate = S_COLLECT;
        end else if (w_settle && !w_onehot) begin
          w_se = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_settle) begin
          if (!w_onehot) begin
            w_se     = 1'b1;
            w_nstate = S_HUNT;
          end else if (w_idx == r_exp) begin
            w_cap  = 1'b1;
            w_nexp = r_exp + 3'd1;
            if (r_exp == 3'd7) begin
              w_nstate = S_CHECK;
            end
          end else begin
            w_se = 1'b1;
            if (w_idx == 3'd0) begin
              w_cap  = 1'b1;
              w_nexp = 3'd1;
            end else begin
              w_nstate = S_HUNT;
            end
          end
        end
      end
      S_CHECK: begin
        w_nstate = S_HUNT;
        w_fv     = w_good;
        w_fe     = !w_good;
        w_pend_n = w_start;
      end
      default: w_nstate = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_cnt   <= '0;
      r_exp   <= 3'd0;
      r_pend  <= 1'b0;
      r_ok    <= 8'd0;
      r_dp2   <= 1'b0;
      r_dp5   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_val[i] <= 4'd0;
      end
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt;
      r_exp   <= w_nexp;
      r_pend  <= w_pend_n;
      if (w_cap) begin
        r_val[w_cidx] <= w_dval;
        r_ok[w_cidx]  <= w_cok;
        if (w_cidx == 3'd2) r_dp2 <= w_dp;
        if (w_cidx == 3'd5) r_dp5 <= w_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hh  <= 5'd0;
      r_mm  <= 6'd0;
      r_ss  <= 6'd0;
      r_col <= 1'b0;
      r_fv  <= 1'b0;
      r_fe  <= 1'b0;
      r_se  <= 1'b0;
    end else begin
      r_fv <= w_fv;
      r_fe <= w_fe;
      r_se <= w_se;
      if (w_fv) begin
        r_hh  <= w_h;
        r_mm  <= w_m;
        r_ss  <= w_s;
        r_col <= r_dp2 & r_dp5;
      end
    end
  end

  assign hh          = r_hh;
  assign mm          = r_mm;
  assign ss          = r_ss;
  assign colon_ok    = r_col;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign sync_err    = r_se;

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side monitor for the multiplexed 8-digit seven-segment display bus driven by the digital clock. It samples the chip-select and segment lines and decodes each segment pattern back to a BCD digit. It reassembles a full HH:MM:SS frame and reports it as binary fields with a one-cycle valid strobe. It is used for FPGA loopback self-check and as a scoreboard front end in simulation.

## Interface
Parameters:
- SETTLE, default 16: consecutive cycles a digit selection must be held stable before it is sampled (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  8  digit select, active-low one-hot; bit i selects digit i (digit 0 = hour tens, digit 7 = second units).
- seg  input  8  segment lines, active-low, bit order {dp,g,f,e,d,c,b,a}.
- hh  output  5  decoded hours, binary 0..23.
- mm  output  6  decoded minutes, binary 0..59.
- ss  output  6  decoded seconds, binary 0..59.
- colon_ok  output  1  dp was lit on digits 2 and 5 in the last good frame.
- frame_valid  output  1  one-cycle pulse when hh/mm/ss/colon_ok update.
- frame_err  output  1  one-cycle pulse when a fully captured frame is rejected.
- sync_err  output  1  one-cycle pulse on out-of-order selection or non-one-hot cs held for SETTLE cycles.

## Operation
- cs and seg pass through 2-flop synchronizers (reset value 8'hFF); all logic below uses the synchronized copies cs_s and seg_s.
- Stability counter: cleared whenever cs_s differs from its previous-cycle value, otherwise saturating increment. A selection is "settled" on the cycle the counter reaches SETTLE-1. It is sampled once only, even if held longer.
- Digit decode, from active-high {g..a} after inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern is invalid. dp is captured separately.
- Digits 2 and 5 are separators: their {g..a} content is ignored and only dp is kept.
- State machine:
  - HUNT: wait for a settled cs_s = ~8'h01. Capture digit 0, set expected index to 1, go to COLLECT.
  - COLLECT: on each settled one-hot selection:
    - index == expected: capture the digit and advance expected.
    - index != expected: pulse sync_err and discard the partial frame. If the index is 0, capture it as a new frame start and stay in COLLECT (expected = 1); otherwise go to HUNT.
    - After index 7 is captured, go to CHECK.
  - Settled non-one-hot cs_s in either state (including all-high): pulse sync_err and go to HUNT.
  - CHECK (one cycle): the frame is good when all six numeric digits are valid, hour tens ≤2, hours ≤23, minute tens ≤5, and second tens ≤5.
    - Good: load hh = 10·d0+d1, mm = 10·d3+d4, ss = 10·d6+d7, colon_ok = dp2 & dp5; pulse frame_valid.
    - Bad: pulse frame_err and leave outputs unchanged.
    - Return to HUNT.
- A settled selection of digit 0 arriving during CHECK is not lost: it is processed on the next cycle in HUNT.
- Reset values: hh=0, mm=0, ss=0, colon_ok=0, frame_valid=0, frame_err=0, sync_err=0; state HUNT, counter 0.
- Reset asserted mid-frame discards all partial capture immediately; no pulse is emitted.

## Timing
- Input to synchronized copy: 2 cycles.
- A new cs value seen on cs_s at cycle t settles (is sampled) at cycle t+SETTLE-1, using seg_s of that same cycle.
- frame_valid / frame_err assert exactly 1 cycle after digit 7 is sampled (the CHECK cycle registers the outputs). Outputs change on the same edge the pulse rises.
- hh/mm/ss hold between frames. Pulses are never longer than 1 cycle, and frame_valid and frame_err are mutually exclusive.
- Selections held fewer than SETTLE cycles are ignored completely and do not count as out-of-order.

## Test plan
- Scan 8 digits in order, 20 cycles each, SETTLE=16, showing 23:59:58 with dp on digits 2 and 5 -> one frame_valid 1 cycle after digit 7 sampled; hh=23, mm=59, ss=58, colon_ok=1.
- Same scan showing 24:00:00 -> frame_err pulse; outputs keep their previous values; no frame_valid.
- Digit 4 seg pattern 0x49 (invalid) -> frame_err; a following clean frame 12:34:56 -> frame_valid, hh=12, mm=34, ss=56.
- Scan order 0,1,2,4 -> sync_err on digit 4 settle, state HUNT; the next in-order frame decodes correctly.
- Glitch cs to digit 5 for 3 cycles between digits 1 and 2 -> no sync_err; frame decodes normally.
- Assert rst_n low during digit 3 -> all outputs 0 immediately; a complete frame after release -> frame_valid with the correct values.
